// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port memory between the core's instruction-fetch port
// and its load/store port. Data has fixed priority over fetch. Each granted
// request is latched, the memory is driven for MEM_LAT cycles, and the
// granted port gets a one-cycle ready pulse in the final BUSY cycle. A
// turnaround IDLE cycle always separates two accesses.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   inst_req_i/addr_i   fetch request (held until inst_ready_o)
//   inst_rdata_o        fetched word (passthrough in ready cycle, then held)
//   inst_ready_o        one-cycle fetch completion pulse
//   data_req_i/we_i/addr_i/wdata_i  load/store request
//   data_rdata_o        load data (passthrough in ready cycle, then held)
//   data_ready_o        one-cycle data completion pulse
//   stall_o             core stall while a request is outstanding
//   mem_ce_o/we_o/addr_o/wdata_o/rdata_i  memory macro interface
//
// Optional feature (macro ARB_PERF_EN): perf_inst_cnt_o, perf_data_cnt_o,
// perf_stall_cnt_o count completed fetches, completed data accesses and
// stall cycles (wrap modulo 2^32, cleared by reset).

module mem_port_arbiter #(
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req_i,
    input  logic [31:0] inst_addr_i,
    output logic [31:0] inst_rdata_o,
    output logic        inst_ready_o,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        data_ready_o,
    output logic        stall_o,
    output logic        mem_ce_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
`ifdef ARB_PERF_EN
    ,
    output logic [31:0] perf_inst_cnt_o,
    output logic [31:0] perf_data_cnt_o,
    output logic [31:0] perf_stall_cnt_o
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    // Counter value of the completion cycle (the MEM_LAT-th BUSY cycle).
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LAT - 1);

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [31:0]      addr_r;
    logic             we_r;
    logic [31:0]      wdata_r;
    logic [31:0]      inst_rdata_r;
    logic [31:0]      data_rdata_r;
    logic             busy_s;
    logic             done_s;
    logic             inst_done_s;
    logic             data_done_s;
    logic             stall_s;

    // Completion decode and core stall.
    always_comb begin
        busy_s      = (state_r == BUSY_I) || (state_r == BUSY_D);
        done_s      = busy_s && (cnt_r == LAST_CNT);
        inst_done_s = done_s && (state_r == BUSY_I);
        data_done_s = done_s && (state_r == BUSY_D);
        // Gated by rst so the stall is low for the whole reset window.
        stall_s     = rst & ((inst_req_i & ~inst_done_s) | (data_req_i & ~data_done_s));
    end

    // Next-state logic: data wins in IDLE, every access returns to IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (data_req_i) begin
                    state_s = BUSY_D;
                end else if (inst_req_i) begin
                    state_s = BUSY_I;
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY_I, BUSY_D: begin
                if (done_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = state_r;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Request latch on the grant edge and latency counter during BUSY.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r   <= '0;
            addr_r  <= 32'h0000_0000;
            we_r    <= 1'b0;
            wdata_r <= 32'h0000_0000;
        end else if (state_r == IDLE) begin
            cnt_r <= '0;
            if (data_req_i) begin
                addr_r  <= data_addr_i;
                we_r    <= data_we_i;
                wdata_r <= data_wdata_i;
            end else if (inst_req_i) begin
                addr_r  <= inst_addr_i;
                we_r    <= 1'b0;
                wdata_r <= 32'h0000_0000;
            end
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // Read-data capture in the completion cycle; stores leave data_rdata alone.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inst_rdata_r <= 32'h0000_0000;
            data_rdata_r <= 32'h0000_0000;
        end else begin
            if (inst_done_s) begin
                inst_rdata_r <= mem_rdata_i;
            end
            if (data_done_s && !we_r) begin
                data_rdata_r <= mem_rdata_i;
            end
        end
    end

    // Memory drive and port returns; rdata passes through in the ready cycle.
    always_comb begin
        mem_ce_o     = 1'b0;
        mem_we_o     = 1'b0;
        mem_addr_o   = 32'h0000_0000;
        mem_wdata_o  = 32'h0000_0000;
        inst_ready_o = inst_done_s;
        data_ready_o = data_done_s;
        stall_o      = stall_s;
        if (busy_s) begin
            mem_ce_o   = 1'b1;
            mem_addr_o = addr_r;
            if (state_r == BUSY_D) begin
                mem_we_o    = we_r;
                mem_wdata_o = wdata_r;
            end else begin
                mem_we_o    = 1'b0;
                mem_wdata_o = 32'h0000_0000;
            end
        end else begin
            mem_ce_o = 1'b0;
        end
        if (inst_done_s) begin
            inst_rdata_o = mem_rdata_i;
        end else begin
            inst_rdata_o = inst_rdata_r;
        end
        if (data_done_s && !we_r) begin
            data_rdata_o = mem_rdata_i;
        end else begin
            data_rdata_o = data_rdata_r;
        end
    end

`ifdef ARB_PERF_EN
    logic [31:0] perf_inst_cnt_r;
    logic [31:0] perf_data_cnt_r;
    logic [31:0] perf_stall_cnt_r;

    // Performance counters, wrapping modulo 2^32.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_inst_cnt_r  <= 32'h0000_0000;
            perf_data_cnt_r  <= 32'h0000_0000;
            perf_stall_cnt_r <= 32'h0000_0000;
        end else begin
            if (inst_done_s) begin
                perf_inst_cnt_r <= perf_inst_cnt_r + 32'd1;
            end
            if (data_done_s) begin
                perf_data_cnt_r <= perf_data_cnt_r + 32'd1;
            end
            if (stall_s) begin
                perf_stall_cnt_r <= perf_stall_cnt_r + 32'd1;
            end
        end
    end

    assign perf_inst_cnt_o  = perf_inst_cnt_r;
    assign perf_data_cnt_o  = perf_data_cnt_r;
    assign perf_stall_cnt_o = perf_stall_cnt_r;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Table-driven bench for mem_port_arbiter (MEM_LAT=2). Each vector gives the
// inputs for one clock cycle and the outputs expected in that cycle; inputs
// change on the falling edge and outputs are sampled 1 ns later.
// A small memory model answers reads by address.

module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        inst_req_i;
    logic [31:0] inst_addr_i;
    logic [31:0] inst_rdata_o;
    logic        inst_ready_o;
    logic        data_req_i;
    logic        data_we_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic [31:0] data_rdata_o;
    logic        data_ready_o;
    logic        stall_o;
    logic        mem_ce_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
`ifdef ARB_PERF_EN
    logic [31:0] perf_inst_cnt_o;
    logic [31:0] perf_data_cnt_o;
    logic [31:0] perf_stall_cnt_o;
`endif

    mem_port_arbiter #(.MEM_LAT(2), .CNT_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .inst_req_i   (inst_req_i),
        .inst_addr_i  (inst_addr_i),
        .inst_rdata_o (inst_rdata_o),
        .inst_ready_o (inst_ready_o),
        .data_req_i   (data_req_i),
        .data_we_i    (data_we_i),
        .data_addr_i  (data_addr_i),
        .data_wdata_i (data_wdata_i),
        .data_rdata_o (data_rdata_o),
        .data_ready_o (data_ready_o),
        .stall_o      (stall_o),
        .mem_ce_o     (mem_ce_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rdata_i  (mem_rdata_i)
`ifdef ARB_PERF_EN
        ,
        .perf_inst_cnt_o  (perf_inst_cnt_o),
        .perf_data_cnt_o  (perf_data_cnt_o),
        .perf_stall_cnt_o (perf_stall_cnt_o)
`endif
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: two fixed words, everything else derived from the address.
    always_comb begin
        if (mem_addr_o == 32'h0000_0010) begin
            mem_rdata_i = 32'h0010_0093;
        end else if (mem_addr_o == 32'h0000_0100) begin
            mem_rdata_i = 32'hDEAD_BEEF;
        end else begin
            mem_rdata_i = mem_addr_o ^ 32'hA5A5_0000;
        end
    end

    typedef struct packed {
        logic        ce;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        iready;
        logic        dready;
        logic [31:0] irdata;
        logic [31:0] drdata;
        logic        stall;
    } out_t;

    typedef struct {
        logic        r;
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic        dwe;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        out_t        exp;
    } vec_t;

    vec_t vecs[$];
    int   n_vec;
    int   n_err;
    int   m_inst;
    int   m_data;
    int   m_stall;

    localparam logic [31:0] I1 = 32'h0010_0093;
    localparam logic [31:0] I2 = 32'hA5A5_0020;
    localparam logic [31:0] DB = 32'hDEAD_BEEF;
    localparam logic [31:0] Z  = 32'h0000_0000;

    task automatic add(input logic r, input logic ireq, input logic [31:0] iaddr,
                       input logic dreq, input logic dwe, input logic [31:0] daddr,
                       input logic [31:0] dwdata, input logic ce, input logic we,
                       input logic [31:0] maddr, input logic [31:0] mwdata,
                       input logic ir, input logic dr, input logic [31:0] ird,
                       input logic [31:0] drd, input logic st);
        vec_t v;
        v.r = r; v.ireq = ireq; v.iaddr = iaddr; v.dreq = dreq;
        v.dwe = dwe; v.daddr = daddr; v.dwdata = dwdata;
        v.exp = '{ce: ce, we: we, addr: maddr, wdata: mwdata, iready: ir,
                  dready: dr, irdata: ird, drdata: drd, stall: st};
        vecs.push_back(v);
    endtask

    function automatic out_t sample();
        sample = '{ce: mem_ce_o, we: mem_we_o, addr: mem_addr_o, wdata: mem_wdata_o,
                   iready: inst_ready_o, dready: data_ready_o, irdata: inst_rdata_o,
                   drdata: data_rdata_o, stall: stall_o};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    initial begin
        out_t act;
        int   cyc;
        n_vec = 0; n_err = 0; m_inst = 0; m_data = 0; m_stall = 0;
        rst = 1'b0; inst_req_i = 1'b0; inst_addr_i = Z; data_req_i = 1'b0;
        data_we_i = 1'b0; data_addr_i = Z; data_wdata_i = Z;

        //   r     ireq  iaddr          dreq  dwe   daddr          dwdata        | ce    we    maddr          mwdata         ir    dr    irdata drdata st
        // reset: outputs 0, stall gated even with requests present
        add(1'b0, 1'b0, Z,             1'b0, 1'b0, Z,             Z,             1'b0, 1'b0, Z,             Z,             1'b0, 1'b0, Z,  Z,  1'b0);
        add(1'b0, 1'b1, 32'h10,        1'b1, 1'b0, 32'h100,       Z,             1'b0, 1'b0, Z,             Z,             1'b0, 1'b0, Z,  Z,  1'b0);
        // single fetch at 0x10
        add(1'b1, 1'b1, 32'h10,        1'b0, 1'b0, Z,             Z,             1'b0, 1'b0, Z,             Z,             1'b0, 1'b0, Z,  Z,  1'b1);
        add(1'b1, 1'b1, 32'h10,        1'b0, 1'b0, Z,             Z,             1'b1, 1'b0, 32'h10,        Z,             1'b0, 1'b0, Z,  Z,  1'b1);
        add(1'b1, 1'b1, 32'h10,        1'b0, 1'b0, Z,             Z,             1'b1, 1'b0, 32'h10,        Z,             1'b1, 1'b0, I1, Z,  1'b0);
        add(1'b1, 1'b0, Z,             1'b0, 1'b0, Z,             Z,             1'b0, 1'b0, Z,             Z,             1'b0, 1'b0, I1, Z,  1'b0);
        // conflict: data load 0x100 first, turnaround, then fetch 0x20
        add(1'b1, 1'b1, 32'h20,        1'b1, 1'b0, 32'h100,       Z,             1'b0, 1'b0, Z,             Z,             1'b0, 1'b0, I1, Z,  1'b1);
        add(1'b1, 1'b1, 32'h20,        1'b1, 1'b0, 32'h100,       Z,             1'b1, 1'b0, 32'h100,       Z,             1'b0, 1'b0, I1, Z,  1'b1);
        add(1'b1, 1'b1, 32'h20,        1'b1, 1'b0, 32'h100,       Z,             1'b1, 1'b0, 32'h100,       Z,             1'b0, 1'b1, I1, DB, 1'b1);
        add(1'b1, 1'b1, 32'h20,        1'b0, 1'b0, Z,             Z,             1'b0, 1'b0, Z,             Z,             1'b0, 1'b0, I1, DB, 1'b1);
        add(1'b1, 1'b1, 32'h20,        1'b0, 1'b0, Z,             Z,             1'b1, 1'b0, 32'h20,        Z,             1'b0, 1'b0, I1, DB, 1'b1);
        add(1'b1, 1'b1, 32'h20,        1'b0, 1'b0, Z,             Z,             1'b1, 1'b0, 32'h20,        Z,             1'b1, 1'b0, I2, DB, 1'b0);
        add(1'b1, 1'b0, Z,             1'b0, 1'b0, Z,             Z,             1'b0, 1'b0, Z,             Z,             1'b0, 1'b0, I2, DB, 1'b0);
        // store 0x200 <- 0x12345678; inputs changed mid-access are ignored
        add(1'b1, 1'b0, Z,             1'b1, 1'b1, 32'h200,       32'h1234_5678, 1'b0, 1'b0, Z,             Z,             1'b0, 1'b0, I2, DB, 1'b1);
        add(1'b1, 1'b0, Z,             1'b1, 1'b1, 32'h200,       32'h1234_5678, 1'b1, 1'b1, 32'h200,       32'h1234_5678, 1'b0, 1'b0, I2, DB, 1'b1);
        add(1'b1, 1'b0, Z,             1'b1, 1'b0, 32'h204,       32'hFFFF_FFFF, 1'b1, 1'b1, 32'h200,       32'h1234_5678, 1'b0, 1'b1, I2, DB, 1'b0);
        add(1'b1, 1'b0, Z,             1'b0, 1'b0, Z,             Z,             1'b0, 1'b0, Z,             Z,             1'b0, 1'b0, I2, DB, 1'b0);
        // fetch address changes 0x10 -> 0x14 mid-access, req dropped before ready
        add(1'b1, 1'b1, 32'h10,        1'b0, 1'b0, Z,             Z,             1'b0, 1'b0, Z,             Z,             1'b0, 1'b0, I2, DB, 1'b1);
        add(1'b1, 1'b1, 32'h14,        1'b0, 1'b0, Z,             Z,             1'b1, 1'b0, 32'h10,        Z,             1'b0, 1'b0, I2, DB, 1'b1);
        add(1'b1, 1'b0, 32'h14,        1'b0, 1'b0, Z,             Z,             1'b1, 1'b0, 32'h10,        Z,             1'b1, 1'b0, I1, DB, 1'b0);
        add(1'b1, 1'b0, Z,             1'b0, 1'b0, Z,             Z,             1'b0, 1'b0, Z,             Z,             1'b0, 1'b0, I1, DB, 1'b0);
        // reset in the first BUSY cycle of a fetch, then a clean fetch
        add(1'b1, 1'b1, 32'h10,        1'b0, 1'b0, Z,             Z,             1'b0, 1'b0, Z,             Z,             1'b0, 1'b0, I1, DB, 1'b1);
        add(1'b0, 1'b1, 32'h10,        1'b0, 1'b0, Z,             Z,             1'b0, 1'b0, Z,             Z,             1'b0, 1'b0, Z,  Z,  1'b0);
        add(1'b1, 1'b1, 32'h10,        1'b0, 1'b0, Z,             Z,             1'b0, 1'b0, Z,             Z,             1'b0, 1'b0, Z,  Z,  1'b1);
        add(1'b1, 1'b1, 32'h10,        1'b0, 1'b0, Z,             Z,             1'b1, 1'b0, 32'h10,        Z,             1'b0, 1'b0, Z,  Z,  1'b1);
        add(1'b1, 1'b1, 32'h10,        1'b0, 1'b0, Z,             Z,             1'b1, 1'b0, 32'h10,        Z,             1'b1, 1'b0, I1, Z,  1'b0);
        add(1'b1, 1'b0, Z,             1'b0, 1'b0, Z,             Z,             1'b0, 1'b0, Z,             Z,             1'b0, 1'b0, I1, Z,  1'b0);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].r; inst_req_i = vecs[i].ireq; inst_addr_i = vecs[i].iaddr;
            data_req_i = vecs[i].dreq; data_we_i = vecs[i].dwe;
            data_addr_i = vecs[i].daddr; data_wdata_i = vecs[i].dwdata;
            #1;
            act = sample();
            n_vec++;
            if (act !== vecs[i].exp) begin
                n_err++;
                $display("FAIL vec%0d: got ce=%b we=%b addr=%h wdata=%h ir=%b dr=%b ird=%h drd=%h st=%b, expected ce=%b we=%b addr=%h wdata=%h ir=%b dr=%b ird=%h drd=%h st=%b",
                         i, act.ce, act.we, act.addr, act.wdata, act.iready, act.dready,
                         act.irdata, act.drdata, act.stall, vecs[i].exp.ce, vecs[i].exp.we,
                         vecs[i].exp.addr, vecs[i].exp.wdata, vecs[i].exp.iready,
                         vecs[i].exp.dready, vecs[i].exp.irdata, vecs[i].exp.drdata,
                         vecs[i].exp.stall);
            end
            // Perf model counts from the last reset cycle onwards.
            if (vecs[i].r == 1'b0) begin
                m_inst = 0; m_data = 0; m_stall = 0;
            end else begin
                m_inst  += int'(vecs[i].exp.iready);
                m_data  += int'(vecs[i].exp.dready);
                m_stall += int'(vecs[i].exp.stall);
            end
        end

        // Load from 0x300 with a bounded wait: ready exactly MEM_LAT cycles later.
        @(negedge clk);
        data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h300;
        #1;
        check("load_stall", {31'd0, stall_o}, 32'd1);
        cyc = 0;
        while (data_ready_o !== 1'b1 && cyc < 8) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check("load_latency", cyc, 32'd2);
        check("load_rdata", data_rdata_o, 32'hA5A5_0300);
        m_data  += 1;
        m_stall += 2;
        @(negedge clk);
        data_req_i = 1'b0;
        #1;
        check("load_hold", data_rdata_o, 32'hA5A5_0300);
        check("load_idle_ce", {31'd0, mem_ce_o}, 32'd0);

`ifdef ARB_PERF_EN
        check("perf_inst", perf_inst_cnt_o, m_inst);
        check("perf_data", perf_data_cnt_o, m_data);
        check("perf_stall", perf_stall_cnt_o, m_stall);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the core's instruction-fetch port and its load/store port.
- Sits between the riscv core's inst_*/data_* pins and the memory macro.
- Latches each granted request, drives the memory for a fixed latency, and returns read data with a one-cycle ready pulse.
- Raises a stall to the core while any request is still outstanding.

Parameters:
- MEM_LAT, 2, memory access latency in cycles (legal 1..15); the access completes in the MEM_LAT-th BUSY cycle.
- CNT_W, 4, latency counter width; must satisfy 2^CNT_W > MEM_LAT.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- inst_req_i  in  1  fetch request, held until inst_ready_o.
- inst_addr_i  in  32  fetch address.
- inst_rdata_o  out  32  fetched word.
- inst_ready_o  out  1  one-cycle completion pulse for fetch.
- data_req_i  in  1  load/store request, held until data_ready_o.
- data_we_i  in  1  1 = store, 0 = load.
- data_addr_i  in  32  data address.
- data_wdata_i  in  32  store data.
- data_rdata_o  out  32  load data.
- data_ready_o  out  1  one-cycle completion pulse for data.
- stall_o  out  1  core stall request.
- mem_ce_o  out  1  memory chip enable.
- mem_we_o  out  1  memory write enable.
- mem_addr_o  out  32  memory address.
- mem_wdata_o  out  32  memory write data.
- mem_rdata_i  in  32  memory read data, valid in the completion cycle.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE and the counter clears.
  - All outputs go to 0, including both rdata registers.
  - Any in-flight access is discarded; mem_ce_o drops immediately, no ready is issued.
  - Operation resumes in the first cycle after rst returns to 1, in IDLE.
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE:
  - If data_req_i=1, go to BUSY_D; data has fixed priority.
  - Otherwise, if inst_req_i=1, go to BUSY_I.
  - Otherwise stay in IDLE.
  - On the grant edge, latch the address, we and wdata of the granted port, and clear the counter to 0.
- BUSY_x:
  - mem_ce_o=1 and mem_addr_o=latched address.
  - In BUSY_D: mem_we_o=latched we and mem_wdata_o=latched wdata.
  - In BUSY_I: mem_we_o=0 and mem_wdata_o=0.
  - The counter increments each cycle.
- Completion cycle (counter == MEM_LAT-1):
  - The granted port's ready_o=1, combinationally, for exactly this cycle.
  - For a read, mem_rdata_i is captured into that port's rdata register on this edge. rdata_o is combinational passthrough in this cycle and holds the registered value afterwards.
  - A store leaves data_rdata_o unchanged.
  - Next state is always IDLE: one turnaround cycle between accesses, so back-to-back throughput is MEM_LAT+1 cycles per access.
- Request inputs changing during BUSY are ignored; the latched values are used.
- A requester that drops req mid-access still receives its ready pulse.
- Simultaneous requests in IDLE: data wins; fetch waits, keeping inst_req_i high.
- A requester must present its next request in the cycle after its ready pulse, or later.
- Outside BUSY: mem_ce_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0.
- stall_o = (inst_req_i & ~inst_ready_o) | (data_req_i & ~data_ready_o), combinational. It is 0 while rst=0.
- Latency: request seen in IDLE at cycle t gives ready at cycle t+MEM_LAT.
- MEM_LAT=1 gives a single BUSY cycle that is also the completion cycle.

Optional Feature:
- Macro: ARB_PERF_EN.
- When defined, adds three 32-bit outputs:
  - perf_inst_cnt_o: completed fetches.
  - perf_data_cnt_o: completed data accesses.
  - perf_stall_cnt_o: cycles with stall_o=1.
- The counters wrap modulo 2^32 and clear on reset.
- When undefined, these ports and their registers are absent; all other behaviour is identical.

Test Plan:
- Reset mid-access: inst fetch, MEM_LAT=2, pull rst low in the first BUSY cycle -> mem_ce_o=0 immediately, no inst_ready_o, FSM in IDLE after release, rdata outputs 0.
- Single fetch: inst_req_i=1, addr 0x0000_0010, memory returns 0x0010_0093 -> mem_ce_o high 2 cycles, inst_ready_o pulses 2 cycles after the request, inst_rdata_o=0x0010_0093 and held; stall_o high until the ready cycle.
- Conflict: inst and data requests together (data load at 0x100 returns 0xDEAD_BEEF) -> data served first with data_ready_o at t+2; idle turnaround; fetch granted at t+3 with inst_ready_o at t+5; data_rdata_o=0xDEAD_BEEF.
- Store: data_we_i=1, addr 0x200, wdata 0x1234_5678 -> mem_we_o=1 with those values for MEM_LAT cycles, data_ready_o pulse, data_rdata_o unchanged.
- Request change mid-access: inst_addr_i changed from 0x10 to 0x14 during BUSY_I -> mem_addr_o stays 0x10 throughout.
- ARB_PERF_EN: 3 fetches plus 1 load with MEM_LAT=1 -> perf_inst_cnt_o=3, perf_data_cnt_o=1, perf_stall_cnt_o equals the counted stall cycles.
